// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer:
// state enum, opcode class values, datapath mux encodings and the
// opcode-class decode helper used by the class decoder.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // inst[6:2] values of the supported opcode classes
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    // one-hot opcode class; all-zero means no legal class
    typedef struct packed {
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic branch;
        logic load;
        logic store;
        logic opimm;
        logic op;
    } opclass_t;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_ALU   = 2'd1;
    localparam logic [1:0] PC_SRC_TRAP  = 2'd2;

    localparam logic [1:0] A_SEL_RS1  = 2'd0;
    localparam logic [1:0] A_SEL_PC   = 2'd1;
    localparam logic [1:0] A_SEL_ZERO = 2'd2;

    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_CMP   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Map an inst[6:2] opcode field to its one-hot class (zero if unknown)
    function automatic opclass_t decode_class(input logic [4:0] opc);
        opclass_t c;
        c = '0;
        case (opc)
            OPC_LUI:    c.lui    = 1'b1;
            OPC_AUIPC:  c.auipc  = 1'b1;
            OPC_JAL:    c.jal    = 1'b1;
            OPC_JALR:   c.jalr   = 1'b1;
            OPC_BRANCH: c.branch = 1'b1;
            OPC_LOAD:   c.load   = 1'b1;
            OPC_STORE:  c.store  = 1'b1;
            OPC_OPIMM:  c.opimm  = 1'b1;
            OPC_OP:     c.op     = 1'b1;
            default:    c        = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the sequencer (master) and the datapath (slave):
// instruction/status inputs to the sequencer and all datapath strobes.
interface mc_ctrl_fsm_if;

    logic [31:0] inst;
    logic        branch_taken;
    logic        mem_ready;

    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  alu_op;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic        instret;
    logic [2:0]  state_o;

    modport master (
        input  inst, branch_taken, mem_ready,
        output ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel, alu_op,
               mem_req, mem_we, mem_addr_sel, rf_we, wb_sel,
               illegal, instret, state_o
    );

    modport slave (
        output inst, branch_taken, mem_ready,
        input  ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel, alu_op,
               mem_req, mem_we, mem_addr_sel, rf_we, wb_sel,
               illegal, instret, state_o
    );

endinterface

// File: rtl/mc_ctrl_fsm_opclass_dec.sv
// Combinational opcode-class decoder: instruction word to one-hot class plus
// an illegal flag. Shared with the immediate generator's format select.
module mc_opclass_dec
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output opclass_t    cls,
    output logic        illegal
);

    // only the opcode field matters for classification
    logic unused_inst_hi;
    assign unused_inst_hi = ^inst[31:7];

    // Classify inst[6:2]; a non-32-bit encoding or unknown class is illegal
    always_comb begin
        cls     = decode_class(inst[6:2]);
        illegal = (inst[1:0] != 2'b11) || (cls == '0);
        if (illegal) begin
            cls = '0;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Build option: MC_CTRL_MEM_STALL_EN makes FETCH and MEM wait for mem_ready;
// without it every memory access completes in a single cycle.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_fsm_if.master bus
);

    state_t   state_q;
    state_t   state_d;
    opclass_t dec_cls;
    opclass_t cls_q;
    logic     dec_illegal;
    logic     illegal_q;
    logic     trap_pulsed_q;
    logic     mem_done;

    mc_opclass_dec u_dec (
        .inst    (bus.inst),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

`ifdef MC_CTRL_MEM_STALL_EN
    assign mem_done = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_done = 1'b1;
`endif

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch decoded class in DECODE and remember the one-shot trap PC write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q         <= '0;
            illegal_q     <= 1'b0;
            trap_pulsed_q <= 1'b0;
        end else begin
            if (state_q == ST_DECODE) begin
                cls_q     <= dec_cls;
                illegal_q <= dec_illegal;
            end
            if (state_q == ST_TRAP) begin
                trap_pulsed_q <= 1'b1;
            end
        end
    end

    // Next-state selection from current state, class and memory completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (mem_done) state_d = ST_DECODE;
            ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                if (cls_q.load || cls_q.store) begin
                    state_d = ST_MEM;
                end else if (cls_q.branch) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM:    if (mem_done) state_d = cls_q.store ? ST_FETCH : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Datapath strobes per state; everything is forced low while in reset
    always_comb begin
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_src       = PC_SRC_PLUS4;
        bus.alu_a_sel    = A_SEL_RS1;
        bus.alu_b_sel    = B_SEL_RS2;
        bus.alu_op       = ALU_ADD;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.rf_we        = 1'b0;
        bus.wb_sel       = WB_ALU;
        bus.instret      = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_req      = 1'b1;
                    bus.mem_addr_sel = 1'b0;
                    bus.ir_we        = mem_done;
                    bus.pc_we        = mem_done;
                    bus.pc_src       = PC_SRC_PLUS4;
                end
                ST_DECODE: begin
                    bus.alu_a_sel = A_SEL_PC;
                    bus.alu_b_sel = B_SEL_IMM;
                    bus.alu_op    = ALU_ADD;
                end
                ST_EXEC: begin
                    if (cls_q.op) begin
                        bus.alu_op = ALU_FUNCT;
                    end else if (cls_q.opimm) begin
                        bus.alu_b_sel = B_SEL_IMM;
                        bus.alu_op    = ALU_FUNCT;
                    end else if (cls_q.load || cls_q.store) begin
                        bus.alu_b_sel = B_SEL_IMM;
                    end else if (cls_q.lui) begin
                        bus.alu_a_sel = A_SEL_ZERO;
                        bus.alu_b_sel = B_SEL_IMM;
                    end else if (cls_q.auipc) begin
                        bus.alu_a_sel = A_SEL_PC;
                        bus.alu_b_sel = B_SEL_IMM;
                    end else if (cls_q.jal) begin
                        bus.alu_a_sel = A_SEL_PC;
                        bus.alu_b_sel = B_SEL_IMM;
                        bus.pc_we     = 1'b1;
                        bus.pc_src    = PC_SRC_ALU;
                    end else if (cls_q.jalr) begin
                        bus.alu_b_sel = B_SEL_IMM;
                        bus.pc_we     = 1'b1;
                        bus.pc_src    = PC_SRC_ALU;
                    end else if (cls_q.branch) begin
                        bus.alu_op  = ALU_CMP;
                        bus.pc_we   = bus.branch_taken;
                        bus.pc_src  = PC_SRC_ALU;
                        bus.instret = 1'b1;
                    end
                end
                ST_MEM: begin
                    bus.mem_req      = 1'b1;
                    bus.mem_addr_sel = 1'b1;
                    bus.mem_we       = cls_q.store;
                    bus.alu_b_sel    = B_SEL_IMM;
                    bus.instret      = cls_q.store && mem_done;
                end
                ST_WB: begin
                    bus.rf_we   = 1'b1;
                    bus.instret = 1'b1;
                    if (cls_q.load) begin
                        bus.wb_sel = WB_MEM;
                    end else if (cls_q.jal || cls_q.jalr) begin
                        bus.wb_sel = WB_PC4;
                    end else begin
                        bus.wb_sel = WB_ALU;
                    end
                end
                ST_TRAP: begin
                    bus.pc_we  = !trap_pulsed_q;
                    bus.pc_src = RESET_PC_SEL;
                end
                default: begin
                    bus.pc_we = 1'b0;
                end
            endcase
        end
    end

    assign bus.illegal = illegal_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction schedule model built
// from the opcode class, checked every cycle, plus directed literal checks.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

`ifdef MC_CTRL_MEM_STALL_EN
    localparam bit STALL_EN  = 1'b1;
    localparam int LW_CYCLES = 7;
`else
    localparam bit STALL_EN  = 1'b0;
    localparam int LW_CYCLES = 5;
`endif
    localparam logic [1:0] TRAP_SEL = 2'd2;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] a_sel;
        logic       b_sel;
        logic [1:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       instret;
        logic       chk_alu;
        logic       waits;
        logic       pc_we_bt;
        logic       enters_trap;
    } rec_t;

    logic clk;
    logic rst_n;
    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.RESET_PC_SEL(TRAP_SEL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   doneCount = 0;
    bit   inTrap = 1'b0;
    rec_t expQ[$];
    rec_t obsLog[$];
    logic readyPlan[$];
    logic [4:0] legalOps [9] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001,
                                 5'b11000, 5'b00000, 5'b01000, 5'b00100, 5'b01100};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
        end
    endtask

    function automatic bit isLegal(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 1'b0;
        foreach (legalOps[i]) if (w[6:2] == legalOps[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Expected per-cycle schedule of one instruction from its opcode class
    function automatic void buildExpect(input logic [31:0] w);
        rec_t e;
        logic [4:0] o;
        o = w[6:2];
        e = '0; e.st = ST_FETCH; e.mem_req = 1; e.ir_we = 1; e.pc_we = 1; e.waits = 1;
        expQ.push_back(e);
        e = '0; e.st = ST_DECODE;
        expQ.push_back(e);
        if (!isLegal(w)) begin
            e = '0; e.st = ST_TRAP; e.pc_we = 1; e.pc_src = TRAP_SEL; e.illegal = 1; e.enters_trap = 1;
            expQ.push_back(e);
            return;
        end
        e = '0; e.st = ST_EXEC; e.chk_alu = 1;
        case (o)
            5'b01100: begin e.a_sel = 0; e.b_sel = 0; e.alu_op = 2; end
            5'b00100: begin e.a_sel = 0; e.b_sel = 1; e.alu_op = 2; end
            5'b00000, 5'b01000: begin e.a_sel = 0; e.b_sel = 1; e.alu_op = 0; end
            5'b01101: begin e.a_sel = 2; e.b_sel = 1; e.alu_op = 0; end
            5'b00101: begin e.a_sel = 1; e.b_sel = 1; e.alu_op = 0; end
            5'b11011: begin e.a_sel = 1; e.b_sel = 1; e.alu_op = 0; e.pc_we = 1; e.pc_src = 1; end
            5'b11001: begin e.a_sel = 0; e.b_sel = 1; e.alu_op = 0; e.pc_we = 1; e.pc_src = 1; end
            default:  begin e.a_sel = 0; e.b_sel = 0; e.alu_op = 1; e.pc_we_bt = 1; e.pc_src = 1; e.instret = 1; end
        endcase
        expQ.push_back(e);
        if (o == 5'b00000 || o == 5'b01000) begin
            e = '0; e.st = ST_MEM; e.mem_req = 1; e.addr_sel = 1; e.waits = 1;
            e.mem_we = (o == 5'b01000); e.instret = (o == 5'b01000);
            expQ.push_back(e);
        end
        if (o != 5'b11000 && o != 5'b01000) begin
            e = '0; e.st = ST_WB; e.rf_we = 1; e.instret = 1;
            e.wb_sel = (o == 5'b00000) ? 2'd1 : ((o == 5'b11011 || o == 5'b11001) ? 2'd2 : 2'd0);
            expQ.push_back(e);
        end
    endfunction

    function automatic rec_t sample();
        rec_t o;
        o = '0;
        o.st = bus.state_o; o.ir_we = bus.ir_we; o.pc_we = bus.pc_we; o.pc_src = bus.pc_src;
        o.a_sel = bus.alu_a_sel; o.b_sel = bus.alu_b_sel; o.alu_op = bus.alu_op;
        o.mem_req = bus.mem_req; o.mem_we = bus.mem_we; o.addr_sel = bus.mem_addr_sel;
        o.rf_we = bus.rf_we; o.wb_sel = bus.wb_sel; o.illegal = bus.illegal; o.instret = bus.instret;
        return o;
    endfunction

    // Compare every cycle against the model, away from the rising edge
    always @(negedge clk) begin : cmp
        rec_t e;
        rec_t o;
        bit   stall;
        o = sample();
        if (!rst_n) begin
            expQ.delete();
            inTrap = 1'b0;
            checkOutput("rst_state", int'(o.st), int'(ST_FETCH));
            checkOutput("rst_mem_req", int'(o.mem_req), 0);
            checkOutput("rst_mem_we", int'(o.mem_we), 0);
            checkOutput("rst_ir_we", int'(o.ir_we), 0);
            checkOutput("rst_pc_we", int'(o.pc_we), 0);
            checkOutput("rst_rf_we", int'(o.rf_we), 0);
            checkOutput("rst_instret", int'(o.instret), 0);
            checkOutput("rst_illegal", int'(o.illegal), 0);
        end else begin
            if (inTrap) begin
                e = '0; e.st = ST_TRAP; e.illegal = 1;
            end else begin
                if (expQ.size() == 0) begin
                    obsLog.delete();
                    buildExpect(bus.inst);
                end
                e = expQ[0];
            end
            obsLog.push_back(o);
            stall = !inTrap && e.waits && !(STALL_EN ? bus.mem_ready : 1'b1);
            if (stall) begin
                e.ir_we = 0; e.pc_we = 0; e.instret = 0;
            end
            if (e.pc_we_bt) e.pc_we = bus.branch_taken;
            checkOutput("state", int'(o.st), int'(e.st));
            checkOutput("ir_we", int'(o.ir_we), int'(e.ir_we));
            checkOutput("pc_we", int'(o.pc_we), int'(e.pc_we));
            checkOutput("mem_req", int'(o.mem_req), int'(e.mem_req));
            checkOutput("mem_we", int'(o.mem_we), int'(e.mem_we));
            checkOutput("rf_we", int'(o.rf_we), int'(e.rf_we));
            checkOutput("illegal", int'(o.illegal), int'(e.illegal));
            checkOutput("instret", int'(o.instret), int'(e.instret));
            if (e.pc_we) checkOutput("pc_src", int'(o.pc_src), int'(e.pc_src));
            if (e.mem_req) checkOutput("mem_addr_sel", int'(o.addr_sel), int'(e.addr_sel));
            if (e.rf_we) checkOutput("wb_sel", int'(o.wb_sel), int'(e.wb_sel));
            if (e.chk_alu) begin
                checkOutput("alu_a_sel", int'(o.a_sel), int'(e.a_sel));
                checkOutput("alu_b_sel", int'(o.b_sel), int'(e.b_sel));
                checkOutput("alu_op", int'(o.alu_op), int'(e.alu_op));
            end
            if (!inTrap && !stall) begin
                void'(expQ.pop_front());
                if (e.enters_trap) inTrap = 1'b1;
                if (expQ.size() == 0) doneCount++;
            end
        end
    end

    task automatic driveInputs(input int stallPct, input int btMode);
        if (readyPlan.size() > 0) bus.mem_ready = readyPlan.pop_front();
        else bus.mem_ready = ($urandom_range(0, 99) >= stallPct);
        bus.branch_taken = (btMode == 2) ? 1'($urandom_range(0, 1)) : (btMode == 1);
    endtask

    // Run one instruction from FETCH until the model sees it finish
    task automatic applyStimulus(input logic [31:0] word, input int stallPct,
                                 input int btMode, output int cycles);
        int start;
        int n;
        start = doneCount;
        bus.inst = word;
        driveInputs(stallPct, btMode);
        n = 0;
        while (doneCount == start && n < 80) begin
            @(posedge clk); #1;
            n++;
            if (doneCount == start) driveInputs(stallPct, btMode);
        end
        checkOutput("instr_completed", doneCount - start, 1);
        readyPlan.delete();
        cycles = obsLog.size();
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int cyc;
        int cnt;
        logic [31:0] w;
        rst_n = 1'b0;
        bus.inst = 32'h0;
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        #3;
        checkOutput("reset_state", int'(bus.state_o), int'(ST_FETCH));
        checkOutput("reset_illegal", int'(bus.illegal), 0);
        checkOutput("reset_mem_req", int'(bus.mem_req), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] ADDI x1,x0,5");
        applyStimulus(32'h00500093, 0, 0, cyc);
        checkOutput("addi_cycles", cyc, 4);
        checkOutput("addi_st0", int'(obsLog[0].st), int'(ST_FETCH));
        checkOutput("addi_st1", int'(obsLog[1].st), int'(ST_DECODE));
        checkOutput("addi_st2", int'(obsLog[2].st), int'(ST_EXEC));
        checkOutput("addi_st3", int'(obsLog[3].st), int'(ST_WB));
        checkOutput("addi_b_sel", int'(obsLog[2].b_sel), 1);
        checkOutput("addi_rf_we", int'(obsLog[3].rf_we), 1);
        checkOutput("addi_wb_sel", int'(obsLog[3].wb_sel), 0);
        cnt = 0;
        foreach (obsLog[i]) cnt += int'(obsLog[i].instret);
        checkOutput("addi_instret_count", cnt, 1);

        $display("[TB] LW with two MEM wait cycles");
        readyPlan = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        applyStimulus(32'h0000A103, 0, 0, cyc);
        checkOutput("lw_cycles", cyc, LW_CYCLES);
        cnt = 0;
        foreach (obsLog[i]) cnt += int'(obsLog[i].mem_we);
        checkOutput("lw_mem_we_count", cnt, 0);
        checkOutput("lw_wb_rf_we", int'(obsLog[cyc-1].rf_we), 1);
        checkOutput("lw_wb_sel", int'(obsLog[cyc-1].wb_sel), 1);

        $display("[TB] BEQ taken / not taken");
        applyStimulus(32'h00208463, 0, 1, cyc);
        checkOutput("beq_t_cycles", cyc, 3);
        checkOutput("beq_t_pc_we", int'(obsLog[2].pc_we), 1);
        checkOutput("beq_t_pc_src", int'(obsLog[2].pc_src), 1);
        cnt = 0;
        foreach (obsLog[i]) cnt += int'(obsLog[i].rf_we);
        checkOutput("beq_t_rf_we_count", cnt, 0);
        applyStimulus(32'h00208463, 0, 0, cyc);
        checkOutput("beq_nt_cycles", cyc, 3);
        checkOutput("beq_nt_pc_we", int'(obsLog[2].pc_we), 0);
        cnt = 0;
        foreach (obsLog[i]) cnt += int'(obsLog[i].rf_we);
        checkOutput("beq_nt_rf_we_count", cnt, 0);

        $display("[TB] JAL");
        applyStimulus(32'h008000EF, 0, 0, cyc);
        checkOutput("jal_cycles", cyc, 4);
        checkOutput("jal_pc_src", int'(obsLog[2].pc_src), 1);
        checkOutput("jal_wb_rf_we", int'(obsLog[3].rf_we), 1);
        checkOutput("jal_wb_sel", int'(obsLog[3].wb_sel), 2);

        $display("[TB] reset during MEM of SW");
        bus.inst = 32'h0020A023;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("sw_in_mem", int'(bus.state_o), int'(ST_MEM));
        checkOutput("sw_mem_we_before", int'(bus.mem_we), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("sw_rst_mem_req", int'(bus.mem_req), 0);
        checkOutput("sw_rst_mem_we", int'(bus.mem_we), 0);
        checkOutput("sw_rst_state", int'(bus.state_o), int'(ST_FETCH));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(32'h00500093, 0, 0, cyc);
        checkOutput("restart_st0", int'(obsLog[0].st), int'(ST_FETCH));
        checkOutput("restart_cycles", cyc, 4);

        $display("[TB] random legal instructions");
        for (int i = 0; i < 300; i++) begin
            w = $urandom();
            w[6:0] = {legalOps[$urandom_range(0, 8)], 2'b11};
            applyStimulus(w, 30, 2, cyc);
        end

        $display("[TB] illegal word 0x00000000");
        applyStimulus(32'h00000000, 0, 0, cyc);
        checkOutput("trap_cycles", cyc, 3);
        checkOutput("trap_state", int'(obsLog[2].st), int'(ST_TRAP));
        checkOutput("trap_illegal", int'(obsLog[2].illegal), 1);
        checkOutput("trap_pc_we", int'(obsLog[2].pc_we), 1);
        repeat (20) @(posedge clk);
        #1;
        cnt = 0;
        for (int i = 3; i < obsLog.size(); i++)
            cnt += int'(obsLog[i].pc_we) + int'(obsLog[i].mem_req) + int'(obsLog[i].rf_we) + int'(obsLog[i].ir_we);
        checkOutput("trap_hold_strobes", cnt, 0);
        checkOutput("trap_hold_len", obsLog.size(), 23);
        pulseReset();

        $display("[TB] random illegal words");
        for (int i = 0; i < 8; i++) begin
            do begin
                w = $urandom();
                if (i % 2 == 0) w[1:0] = 2'b11;
            end while (isLegal(w));
            applyStimulus(w, 30, 2, cyc);
            repeat (4) @(posedge clk);
            #1;
            pulseReset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
